board_ctrl: RTL and testbench
=============================

Name: board_ctrl

Overview:
- Authoritative Connect-Four board state. Holds grid and column_counts, and accepts moves from two sources: human drop buttons, and the minimax engine's opt/move pulse.
- Feeds grid, column_counts and player back to the minimax engine. This is the consumer end of the engine's opt/move interface.
- After every accepted placement it runs a fixed-length sequential win/draw scan, then hands the turn over.

Parameters:
- SCAN_LEN, 168, CHECK cycles per placement (42 start cells x 4 directions).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- sw  input  1  1 = AI plays side 1; 0 = two-player, drop places for either side
- col_sel  input  3  human column select 0..6; values 7 treated as illegal
- drop  input  1  one-cycle drop request (already debounced)
- ai_opt  input  7  engine's chosen cell index (high bit of cell pair)
- ai_move  input  1  one-cycle strobe, ai_opt valid
- grid  output  84  board; cell (c,r) = bits [13-2c+14r : 12-2c+14r]; 10 = AI/side1, 01 = human/side0, 00 = empty
- column_counts  output  21  pieces per column; column c = bits [3c+2 : 3c], range 0..6
- player  output  1  side to move: 0 = human/side0, 1 = AI/side1
- busy  output  1  high while in CHECK
- illegal  output  1  one-cycle pulse on a rejected or substituted move
- winner  output  2  00 none, 01 side0, 10 side1, 11 draw
- game_over  output  1  high in OVER

Behaviour:
- Reset: grid=0, column_counts=0, player=0, busy=0, illegal=0, winner=00, game_over=0, state=TURN. rst mid-CHECK aborts the scan immediately.
- States: TURN, CHECK, OVER.
- Move source in TURN:
  - player=0: drop is accepted.
  - player=1 and sw=1: ai_move is accepted; drop is ignored.
  - player=1 and sw=0: drop is accepted and places a 10 piece.
  - If drop and ai_move arrive in the same cycle, only the valid source for the current side is used.
- Human placement, column c=col_sel:
  - If c<=6 and count<6: next cycle write the cell at row=count, set count+1, enter CHECK.
  - Otherwise pulse illegal; grid, column_counts and player are unchanged; stay in TURN.
- AI placement decode:
  - row = ai_opt/14; c = (13 - ai_opt%14)/2.
  - Valid iff ai_opt<=83, ai_opt odd, and row == column_counts[c].
  - Valid: write 10 at that cell, count+1, enter CHECK.
  - Invalid: pulse illegal and place 10 in the lowest-index non-full column instead, then enter CHECK. No deadlock: the engine only re-arms when player drops to 0.
- Latency: placement is visible on grid/column_counts exactly 1 cycle after the accepted strobe. busy rises in that same cycle.
- CHECK:
  - Counter k runs 0..SCAN_LEN-1; start cell = k/4, direction = k%4 (horizontal, vertical, diag-up, diag-down).
  - Windows running off the board are skipped but still consume their cycle.
  - A window of 4 equal non-empty cells records that side as winner. The first hit is kept.
  - At k=SCAN_LEN-1:
    - win found: set winner, game_over=1, go to OVER.
    - else all seven counts ==6: winner=11, go to OVER.
    - else toggle player, busy=0, go to TURN.
  - player does not change during CHECK.
  - drop and ai_move are ignored during CHECK.
- OVER: all inputs ignored except rst; outputs frozen.
- Arithmetic: counts are 3-bit, saturated by the ==6 check and never wrap. All index math is done in 7 bits.

Optional Feature:
- Macro UNDO_EN.
- Defined:
  - Adds input undo (1 bit).
  - Snapshot registers hold the grid, column_counts and player from before the last accepted placement.
  - undo pulsed in TURN or OVER restores the snapshot, clears winner/game_over, and goes to TURN. Only a single level of undo is kept.
  - A second undo with no new placement in between is ignored.
  - undo during CHECK is ignored.
- Undefined: no undo port, no snapshot registers.

Test Plan:
- rst, then drop with col_sel=3 -> next cycle grid[6]=1, column_counts[11:9]=1, busy=1; after 168 cycles player=1, busy=0, winner=00.
- sw=1, player=1, ai_opt=13, ai_move -> grid[13]=1, column_counts[2:0]=1; after CHECK player=0.
- sw=0, drops in columns 0,0,1,1,2,2,3 -> after the final CHECK winner=01, game_over=1; a following drop leaves grid unchanged.
- Six drops in column 5, then a seventh drop in column 5 -> illegal high for 1 cycle; grid, column_counts and player unchanged; busy stays 0.
- player=1, sw=1, column 6 empty, ai_opt=15 -> illegal pulse, fallback to column 0: grid[13]=1, column_counts[2:0]=1.
- rst asserted at CHECK k=50 -> next cycle all outputs at reset values; state TURN; a new drop is accepted normally.

Source files
------------

// File: rtl/board_ctrl.sv
// board_ctrl: authoritative Connect-Four board.
// Accepts human drops and engine opt/move strobes, then scans for a win or
// draw over a fixed SCAN_LEN cycles before handing over the turn.
// Optional feature: define UNDO_EN to add a single-level undo input.
//
// Strobe semantics: drop and ai_move are valid-only pulses with no ready.
// They are acted on only in TURN, and only for the source that owns the
// current side; while busy is high (CHECK) or game_over is high (OVER)
// every strobe is silently dropped.
module board_ctrl #(
  parameter int SCAN_LEN = 168
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sw,
  input  logic [2:0]  col_sel,
  input  logic        drop,
  input  logic [6:0]  ai_opt,
  input  logic        ai_move,
`ifdef UNDO_EN
  input  logic        undo,
`endif
  output logic [83:0] grid,
  output logic [20:0] column_counts,
  output logic        player,
  output logic        busy,
  output logic        illegal,
  output logic [1:0]  winner,
  output logic        game_over
);

  typedef enum logic [1:0] {S_TURN, S_CHECK, S_OVER} state_t;

  localparam logic [7:0] LAST_K = 8'(SCAN_LEN - 1);

  state_t      state;
  logic [1:0]  board [7][6];   // [column][row], row 0 is the bottom
  logic [2:0]  cnt   [7];
  logic [7:0]  k;
  logic [2:0]  sc, sr;         // start cell of the current window
  logic [1:0]  hit;            // first winning side seen in this scan

`ifdef UNDO_EN
  logic [1:0]  snap_board [7][6];
  logic [2:0]  snap_cnt   [7];
  logic        snap_player;
  logic        snap_valid;
`endif

  logic        undo_req;
  logic [6:0]  ai_row, ai_mod;
  logic [2:0]  ai_col, fb_col;
  logic        ai_ok, fb_any, hum_ok, all_full;
  logic        place_en, bad;
  logic [2:0]  place_col;
  logic [1:0]  place_side;
  logic [1:0]  w0, w1, w2, w3, cur_hit, fin_hit;
  logic        in_rng;

`ifdef UNDO_EN
  assign undo_req = undo && snap_valid && (state != S_CHECK);
`else
  assign undo_req = 1'b0;
`endif

  // Pack the board and column counts onto the flat output buses.
  always_comb begin
    grid          = '0;
    column_counts = '0;
    for (int c = 0; c < 7; c++) begin
      column_counts[3*c +: 3] = cnt[c];
      for (int r = 0; r < 6; r++) grid[14*r + 12 - 2*c +: 2] = board[c][r];
    end
  end

  // Decode both move sources and pick the placement for this cycle.
  always_comb begin
    ai_row     = ai_opt / 7'd14;
    ai_mod     = ai_opt % 7'd14;
    ai_col     = 3'((7'd13 - ai_mod) >> 1);
    ai_ok      = (ai_opt <= 7'd83) && ai_opt[0] && (ai_row == {4'b0, cnt[ai_col]});
    hum_ok     = (col_sel != 3'd7) && (cnt[col_sel] != 3'd6);
    fb_col     = 3'd0;
    fb_any     = 1'b0;
    all_full   = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      if (cnt[i] != 3'd6) begin
        fb_col   = 3'(i);
        fb_any   = 1'b1;
        all_full = 1'b0;
      end
    end
    place_en   = 1'b0;
    place_col  = 3'd0;
    place_side = 2'b01;
    bad        = 1'b0;
    if (state == S_TURN && !undo_req) begin
      if (player && sw) begin
        // engine owns side 1: only ai_move counts
        place_side = 2'b10;
        if (ai_move) begin
          if (ai_ok) begin
            place_en  = 1'b1;
            place_col = ai_col;
          end else begin
            bad       = 1'b1;
            place_en  = fb_any;
            place_col = fb_col;
          end
        end
      end else if (drop) begin
        place_side = player ? 2'b10 : 2'b01;
        if (hum_ok) begin
          place_en  = 1'b1;
          place_col = col_sel;
        end else begin
          bad = 1'b1;
        end
      end
    end
  end

  // Fetch the four cells of the window addressed by (sc, sr, k%4).
  always_comb begin
    w0 = 2'b00; w1 = 2'b00; w2 = 2'b00; w3 = 2'b00;
    in_rng = 1'b0;
    case (k[1:0])
      2'd0: if (sc <= 3'd3) begin
        in_rng = 1'b1;
        w0 = board[sc][sr];        w1 = board[sc + 3'd1][sr];
        w2 = board[sc + 3'd2][sr]; w3 = board[sc + 3'd3][sr];
      end
      2'd1: if (sr <= 3'd2) begin
        in_rng = 1'b1;
        w0 = board[sc][sr];        w1 = board[sc][sr + 3'd1];
        w2 = board[sc][sr + 3'd2]; w3 = board[sc][sr + 3'd3];
      end
      2'd2: if (sc <= 3'd3 && sr <= 3'd2) begin
        in_rng = 1'b1;
        w0 = board[sc][sr];                w1 = board[sc + 3'd1][sr + 3'd1];
        w2 = board[sc + 3'd2][sr + 3'd2];  w3 = board[sc + 3'd3][sr + 3'd3];
      end
      default: if (sc <= 3'd3 && sr >= 3'd3) begin
        in_rng = 1'b1;
        w0 = board[sc][sr];                w1 = board[sc + 3'd1][sr - 3'd1];
        w2 = board[sc + 3'd2][sr - 3'd2];  w3 = board[sc + 3'd3][sr - 3'd3];
      end
    endcase
    cur_hit = (in_rng && w0 != 2'b00 && w0 == w1 && w0 == w2 && w0 == w3) ? w0 : 2'b00;
    fin_hit = (hit != 2'b00) ? hit : cur_hit;
  end

  // Turn/scan/over state machine with all board state and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_TURN;
      for (int c = 0; c < 7; c++) begin
        cnt[c] <= 3'd0;
        for (int r = 0; r < 6; r++) board[c][r] <= 2'b00;
      end
      player    <= 1'b0;
      busy      <= 1'b0;
      illegal   <= 1'b0;
      winner    <= 2'b00;
      game_over <= 1'b0;
      k         <= 8'd0;
      sc        <= 3'd0;
      sr        <= 3'd0;
      hit       <= 2'b00;
`ifdef UNDO_EN
      snap_valid <= 1'b0;
`endif
    end else begin
      illegal <= bad;
      if (undo_req) begin
`ifdef UNDO_EN
        board      <= snap_board;
        cnt        <= snap_cnt;
        player     <= snap_player;
        winner     <= 2'b00;
        game_over  <= 1'b0;
        busy       <= 1'b0;
        state      <= S_TURN;
        snap_valid <= 1'b0;
`endif
      end else begin
        case (state)
          S_TURN: begin
            if (place_en) begin
              board[place_col][cnt[place_col]] <= place_side;
              cnt[place_col] <= cnt[place_col] + 3'd1;
              busy  <= 1'b1;
              k     <= 8'd0;
              sc    <= 3'd0;
              sr    <= 3'd0;
              hit   <= 2'b00;
              state <= S_CHECK;
`ifdef UNDO_EN
              snap_board  <= board;
              snap_cnt    <= cnt;
              snap_player <= player;
              snap_valid  <= 1'b1;
`endif
            end
          end
          S_CHECK: begin
            if (hit == 2'b00) hit <= cur_hit;
            if (k == LAST_K) begin
              busy <= 1'b0;
              if (fin_hit != 2'b00) begin
                winner    <= fin_hit;
                game_over <= 1'b1;
                state     <= S_OVER;
              end else if (all_full) begin
                winner    <= 2'b11;
                game_over <= 1'b1;
                state     <= S_OVER;
              end else begin
                player <= ~player;
                state  <= S_TURN;
              end
            end else begin
              k <= k + 8'd1;
              if (k[1:0] == 2'd3) begin
                if (sc == 3'd6) begin
                  sc <= 3'd0;
                  sr <= sr + 3'd1;
                end else begin
                  sc <= sc + 3'd1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_board_ctrl.sv
// tb_board_ctrl: directed and randomized checks of board_ctrl against a
// board-level model (2D array of pieces, brute-force line search).
module tb_board_ctrl;

  logic        clk = 1'b0;
  logic        rst, sw, drop, ai_move;
  logic [2:0]  col_sel;
  logic [6:0]  ai_opt;
  logic [83:0] grid;
  logic [20:0] column_counts;
  logic        player, busy, illegal, game_over;
  logic [1:0]  winner;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: mb[c][r] = 0 empty, 1 side0, 2 side1
  int mb [7][6];
  int mc [7];
  int mp, mw;
  bit mover;

  board_ctrl dut (
    .clk(clk), .rst(rst), .sw(sw), .col_sel(col_sel), .drop(drop),
    .ai_opt(ai_opt), .ai_move(ai_move), .grid(grid),
    .column_counts(column_counts), .player(player), .busy(busy),
    .illegal(illegal), .winner(winner), .game_over(game_over)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- model ----------------
  task automatic model_reset();
    for (int c = 0; c < 7; c++) begin
      mc[c] = 0;
      for (int r = 0; r < 6; r++) mb[c][r] = 0;
    end
    mp = 0; mw = 0; mover = 0;
  endtask

  task automatic model_place(input int c);
    mb[c][mc[c]] = (mp == 1) ? 2 : 1;
    mc[c] = mc[c] + 1;
  endtask

  function automatic int model_win();
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++)
        for (int d = 0; d < 4; d++) begin
          int dc, dr, ok, v;
          dc = (d == 1) ? 0 : 1;
          dr = (d == 0) ? 0 : ((d == 3) ? -1 : 1);
          if (c + 3*dc > 6 || r + 3*dr > 5 || r + 3*dr < 0) continue;
          v = mb[c][r];
          if (v == 0) continue;
          ok = 1;
          for (int i = 1; i < 4; i++) if (mb[c + i*dc][r + i*dr] != v) ok = 0;
          if (ok == 1) return v;
        end
    return 0;
  endfunction

  task automatic model_end_check();
    int w;
    bit full;
    w = model_win();
    full = 1;
    for (int c = 0; c < 7; c++) if (mc[c] < 6) full = 0;
    if (w != 0) begin mw = w; mover = 1; end
    else if (full) begin mw = 3; mover = 1; end
    else mp = 1 - mp;
  endtask

  task automatic model_ai(input int opt, output int col, output bit bad);
    int row, c;
    row = opt / 14;
    c = (13 - opt % 14) / 2;
    if (opt <= 83 && opt % 2 == 1 && row == mc[c]) begin
      col = c; bad = 0;
    end else begin
      bad = 1; col = -1;
      for (int i = 6; i >= 0; i--) if (mc[i] < 6) col = i;
    end
  endtask

  function automatic logic [83:0] model_grid();
    logic [83:0] g;
    g = '0;
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) begin
        if (mb[c][r] == 1) g[12 - 2*c + 14*r] = 1'b1;
        if (mb[c][r] == 2) g[13 - 2*c + 14*r] = 1'b1;
      end
    return g;
  endfunction

  function automatic logic [20:0] model_counts();
    logic [20:0] v;
    v = '0;
    for (int c = 0; c < 7; c++) v[3*c +: 3] = 3'(mc[c]);
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst = 1'b1; drop = 1'b0; ai_move = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse(input bit d, input int col, input bit a, input int opt);
    drop = d; col_sel = 3'(col); ai_move = a; ai_opt = 7'(opt);
    @(posedge clk); #1;
    drop = 1'b0; ai_move = 1'b0;
  endtask

  // waits out the scan while throwing random strobes at it
  task automatic wait_check(output int n);
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      drop    = 1'($urandom_range(0, 1));
      col_sel = 3'($urandom_range(0, 7));
      ai_move = 1'($urandom_range(0, 1));
      ai_opt  = 7'($urandom_range(0, 127));
      @(posedge clk); #1;
      n++;
    end
    drop = 1'b0; ai_move = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset(); model_reset();
    n_cmp++; if (grid !== 84'd0) begin n_bad++; $display("FAIL reset_grid got %h want 0", grid); end
    n_cmp++; if (column_counts !== 21'd0) begin n_bad++; $display("FAIL reset_counts got %h want 0", column_counts); end
    n_cmp++; if (player !== 1'b0) begin n_bad++; $display("FAIL reset_player got %b want 0", player); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal got %b want 0", illegal); end
    n_cmp++; if (winner !== 2'b00) begin n_bad++; $display("FAIL reset_winner got %b want 00", winner); end
    n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL reset_game_over got %b want 0", game_over); end
  endtask

  task automatic test_first_drop();
    int n;
    sw = 1'b0;
    pulse(1, 3, 0, 0); model_place(3);
    n_cmp++; if (grid[6] !== 1'b1) begin n_bad++; $display("FAIL drop3_bit6 got %b want 1", grid[6]); end
    n_cmp++; if (grid !== model_grid()) begin n_bad++; $display("FAIL drop3_grid got %h want %h", grid, model_grid()); end
    n_cmp++; if (column_counts[11:9] !== 3'd1) begin n_bad++; $display("FAIL drop3_count got %0d want 1", column_counts[11:9]); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL drop3_busy got %b want 1", busy); end
    wait_check(n); model_end_check();
    n_cmp++; if (n != 168) begin n_bad++; $display("FAIL drop3_scan_len got %0d want 168", n); end
    n_cmp++; if (player !== 1'(mp)) begin n_bad++; $display("FAIL drop3_player got %b want %0d", player, mp); end
    n_cmp++; if (winner !== 2'b00) begin n_bad++; $display("FAIL drop3_winner got %b want 00", winner); end
  endtask

  task automatic test_ai_move();
    int col, n;
    bit bad;
    sw = 1'b1;
    model_ai(13, col, bad);
    pulse(1, 5, 1, 13);       // simultaneous drop must be ignored
    model_place(col);
    n_cmp++; if (illegal !== bad) begin n_bad++; $display("FAIL ai13_illegal got %b want %b", illegal, bad); end
    n_cmp++; if (grid[13] !== 1'b1) begin n_bad++; $display("FAIL ai13_bit13 got %b want 1", grid[13]); end
    n_cmp++; if (grid !== model_grid()) begin n_bad++; $display("FAIL ai13_grid got %h want %h", grid, model_grid()); end
    n_cmp++; if (column_counts !== model_counts()) begin n_bad++; $display("FAIL ai13_counts got %h want %h", column_counts, model_counts()); end
    wait_check(n); model_end_check();
    n_cmp++; if (player !== 1'(mp)) begin n_bad++; $display("FAIL ai13_player got %b want %0d", player, mp); end
  endtask

  task automatic test_win();
    int seq [7] = '{0, 0, 1, 1, 2, 2, 3};
    int n;
    do_reset(); model_reset(); sw = 1'b0;
    for (int i = 0; i < 7; i++) begin
      pulse(1, seq[i], 0, 0); model_place(seq[i]);
      wait_check(n); model_end_check();
    end
    n_cmp++; if (winner !== 2'b01) begin n_bad++; $display("FAIL win_winner got %b want 01", winner); end
    n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL win_game_over got %b want 1", game_over); end
    pulse(1, 4, 1, 9);
    n_cmp++; if (grid !== model_grid()) begin n_bad++; $display("FAIL win_frozen_grid got %h want %h", grid, model_grid()); end
    n_cmp++; if (column_counts !== model_counts()) begin n_bad++; $display("FAIL win_frozen_counts got %h want %h", column_counts, model_counts()); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL win_frozen_busy got %b want 0", busy); end
  endtask

  task automatic test_column_full();
    int n;
    do_reset(); model_reset(); sw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pulse(1, 5, 0, 0); model_place(5);
      wait_check(n); model_end_check();
    end
    pulse(1, 5, 0, 0);
    n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL full_illegal got %b want 1", illegal); end
    n_cmp++; if (grid !== model_grid()) begin n_bad++; $display("FAIL full_grid got %h want %h", grid, model_grid()); end
    n_cmp++; if (column_counts !== model_counts()) begin n_bad++; $display("FAIL full_counts got %h want %h", column_counts, model_counts()); end
    n_cmp++; if (player !== 1'(mp)) begin n_bad++; $display("FAIL full_player got %b want %0d", player, mp); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL full_busy got %b want 0", busy); end
    @(posedge clk); #1;
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL full_illegal_pulse got %b want 0", illegal); end
  endtask

  task automatic test_ai_fallback();
    int col, n;
    bit bad;
    do_reset(); model_reset(); sw = 1'b1;
    pulse(1, 3, 0, 0); model_place(3);
    wait_check(n); model_end_check();
    model_ai(15, col, bad);
    pulse(0, 0, 1, 15); model_place(col);
    n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL fallback_illegal got %b want 1", illegal); end
    n_cmp++; if (grid[13] !== 1'b1) begin n_bad++; $display("FAIL fallback_bit13 got %b want 1", grid[13]); end
    n_cmp++; if (column_counts[2:0] !== 3'd1) begin n_bad++; $display("FAIL fallback_count0 got %0d want 1", column_counts[2:0]); end
    n_cmp++; if (grid !== model_grid()) begin n_bad++; $display("FAIL fallback_grid got %h want %h", grid, model_grid()); end
    wait_check(n); model_end_check();
    n_cmp++; if (player !== 1'(mp)) begin n_bad++; $display("FAIL fallback_player got %b want %0d", player, mp); end
  endtask

  task automatic test_reset_mid_check();
    int n;
    do_reset(); model_reset(); sw = 1'b0;
    pulse(1, 2, 0, 0);
    repeat (50) begin @(posedge clk); #1; end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before got %b want 1", busy); end
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    model_reset();
    n_cmp++; if (grid !== 84'd0) begin n_bad++; $display("FAIL midrst_grid got %h want 0", grid); end
    n_cmp++; if (column_counts !== 21'd0) begin n_bad++; $display("FAIL midrst_counts got %h want 0", column_counts); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_cmp++; if (player !== 1'b0 || winner !== 2'b00 || game_over !== 1'b0 || illegal !== 1'b0) begin
      n_bad++; $display("FAIL midrst_status got p%b w%b g%b i%b want p0 w00 g0 i0", player, winner, game_over, illegal);
    end
    pulse(1, 4, 0, 0); model_place(4);
    n_cmp++; if (grid !== model_grid()) begin n_bad++; $display("FAIL midrst_redrop_grid got %h want %h", grid, model_grid()); end
    wait_check(n); model_end_check();
    n_cmp++; if (n != 168) begin n_bad++; $display("FAIL midrst_scan_len got %0d want 168", n); end
    n_cmp++; if (player !== 1'(mp)) begin n_bad++; $display("FAIL midrst_player got %b want %0d", player, mp); end
  endtask

  task automatic test_random_games();
    for (int g = 0; g < 4; g++) begin
      do_reset(); model_reset();
      sw = 1'($urandom_range(0, 1));
      for (int m = 0; m < 60 && !mover; m++) begin
        int col, c, opt, n;
        bit bad;
        if (mp == 1 && sw == 1'b1) begin
          if ($urandom_range(0, 1) == 1) begin
            c = $urandom_range(0, 6);
            while (mc[c] == 6) c = (c + 1) % 7;
            opt = 13 - 2*c + 14*mc[c];
          end else begin
            opt = $urandom_range(0, 127);
          end
          model_ai(opt, col, bad);
          pulse(1'($urandom_range(0, 1)), $urandom_range(0, 7), 1, opt);
        end else begin
          c = $urandom_range(0, 7);
          bad = (c == 7) || (mc[c] == 6);
          col = bad ? -1 : c;
          pulse(1, c, 1'($urandom_range(0, 1)), $urandom_range(0, 127));
        end
        if (col >= 0) model_place(col);
        n_cmp++; if (illegal !== bad) begin n_bad++; $display("FAIL rnd_illegal g%0d m%0d got %b want %b", g, m, illegal, bad); end
        n_cmp++; if (grid !== model_grid()) begin n_bad++; $display("FAIL rnd_grid g%0d m%0d got %h want %h", g, m, grid, model_grid()); end
        n_cmp++; if (column_counts !== model_counts()) begin n_bad++; $display("FAIL rnd_counts g%0d m%0d got %h want %h", g, m, column_counts, model_counts()); end
        n_cmp++; if (busy !== (col >= 0)) begin n_bad++; $display("FAIL rnd_busy g%0d m%0d got %b want %b", g, m, busy, (col >= 0)); end
        if (col >= 0) begin
          wait_check(n); model_end_check();
          n_cmp++; if (n != 168) begin n_bad++; $display("FAIL rnd_scan_len g%0d m%0d got %0d want 168", g, m, n); end
          n_cmp++; if (player !== 1'(mp)) begin n_bad++; $display("FAIL rnd_player g%0d m%0d got %b want %0d", g, m, player, mp); end
          n_cmp++; if (winner !== 2'(mw)) begin n_bad++; $display("FAIL rnd_winner g%0d m%0d got %b want %0d", g, m, winner, mw); end
          n_cmp++; if (game_over !== mover) begin n_bad++; $display("FAIL rnd_game_over g%0d m%0d got %b want %b", g, m, game_over, mover); end
        end else begin
          @(posedge clk); #1;
          n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL rnd_illegal_pulse g%0d m%0d got %b want 0", g, m, illegal); end
        end
      end
      if (mover) begin
        pulse(1, $urandom_range(0, 6), 1, $urandom_range(0, 83));
        n_cmp++; if (grid !== model_grid()) begin n_bad++; $display("FAIL rnd_over_grid g%0d got %h want %h", g, grid, model_grid()); end
        n_cmp++; if (winner !== 2'(mw)) begin n_bad++; $display("FAIL rnd_over_winner g%0d got %b want %0d", g, winner, mw); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; sw = 1'b0; drop = 1'b0; ai_move = 1'b0; col_sel = 3'd0; ai_opt = 7'd0;
    test_reset();
    test_first_drop();
    test_ai_move();
    test_win();
    test_column_full();
    test_ai_fallback();
    test_reset_mid_check();
    test_random_games();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
